branch_issue_arbiter: RTL and testbench

Shares the single b-type execute port of the branch unit among `NUM_REQ` issue requesters. Each requester offers a branch operation (warp id, op, immediate, predicate) on a valid/ready port. A round-robin grant selects one, forwards it to the branch unit and waits for the unit's completion strobe. It exports a per-warp busy bitmap to the warp scheduler. Sits between the issue stage and the branch unit's `s_tvalid_exe`/`s_tready_exe` port.

---
 rtl/branch_issue_arbiter_pkg.sv | 39 +++
 rtl/branch_issue_arbiter_rr.sv | 28 ++
 rtl/branch_issue_arbiter.sv | 133 +++++++++++++
 tb/tb_branch_issue_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_issue_arbiter_pkg.sv
// branch_issue_arbiter_pkg: shared branch op type, arbiter state, error bits and op-validity helper
package branch_issue_arbiter_pkg;

    typedef enum logic [3:0] {
        BRA_NOP      = 4'd0,
        BRA_PC_ADD_4 = 4'd1,
        BRA_JUMP     = 4'd2,
        BRA_JALR     = 4'd3,
        BRA_BEQ      = 4'd4,
        BRA_BNE      = 4'd5,
        BRA_BLT      = 4'd6,
        BRA_BGE      = 4'd7,
        BRA_BLTU     = 4'd8,
        BRA_BGEU     = 4'd9
    } branch_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [4:0]  warp;
        branch_op_t  op;
        logic [31:0] imm;
        logic [31:0] pred;
    } bra_req_t;

    localparam logic [31:0] KIANA_SP_ERR_BRANCH_UNIT_INVALID_OP = 32'h0000_0100;
    localparam logic [31:0] KIANA_SP_ERR_BRANCH_ARB_MISMATCH    = 32'h0001_0000;
    localparam logic [31:0] KIANA_SP_ERR_BRANCH_ARB_TIMEOUT     = 32'h0002_0000;

    // NOP carries no work and PC+4 belongs on the fetch path; neither may reach the branch unit
    function automatic logic bra_is_invalid(input branch_op_t op);
        return (op == BRA_NOP) || (op == BRA_PC_ADD_4);
    endfunction

endpackage

// File: rtl/branch_issue_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i
// Ports: req_i request vector, ptr_i highest-priority index, grant_o one-hot grant,
//        idx_o granted index, any_o some request granted
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);
    localparam int W = $clog2(N);

    // Scan farthest-to-nearest so the request closest to ptr_i is the one left standing
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                idx_o = W'((int'(ptr_i) + k) % N);
                any_o = 1'b1;
            end
        end
        grant_o = any_o ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : '0;
    end

endmodule

// File: rtl/branch_issue_arbiter.sv
// branch_issue_arbiter: round-robin share of the branch unit execute port among NUM_REQ issuers
// Ports: clk/rst_n clock and async active-low reset; req_* per-requester valid/ready op ports;
//        m_tvalid_exe/m_tready_exe + latched op fields towards the branch unit;
//        done_valid/done_warp_id completion from the branch unit; warp_busy in-flight bitmap;
//        grant_id requester of the in-flight op; err sticky error bits
module branch_issue_arbiter
    import branch_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][4:0]            req_warp_id,
    input  branch_op_t [NUM_REQ-1:0]           req_branch_op,
    input  logic [NUM_REQ-1:0][31:0]           req_address_imm,
    input  logic [NUM_REQ-1:0][31:0]           req_pred,
    output logic                               m_tvalid_exe,
    input  logic                               m_tready_exe,
    output logic [4:0]                         warp_id_exe,
    output branch_op_t                         branch_op,
    output logic [31:0]                        address_imm,
    output logic [31:0]                        pred,
    input  logic                               done_valid,
    input  logic [4:0]                         done_warp_id,
    output logic [31:0]                        warp_busy,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic [31:0]                        err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    arb_state_t   state_q, state_d;
    logic [IW-1:0] last_q, last_d, grant_q, grant_d, ptr, win_idx;
    logic [31:0]  busy_q, busy_d, err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    bra_req_t     op_q, op_d;
    logic [NUM_REQ-1:0] elig, win_grant;
    logic         win_any;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) elig[i] = req_valid[i] & ~busy_q[req_warp_id[i]];
    end

    assign ptr = (last_q == IW'(NUM_REQ - 1)) ? '0 : last_q + IW'(1);

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i  (elig),
        .ptr_i  (ptr),
        .grant_o(win_grant),
        .idx_o  (win_idx),
        .any_o  (win_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            busy_q  <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '{warp: 5'd0, op: BRA_NOP, imm: 32'd0, pred: 32'd0};
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE: if (win_any) begin
                last_d = win_idx;
                // invalid ops are consumed so the requester never stalls, but go nowhere
                if (bra_is_invalid(req_branch_op[win_idx])) err_d = err_q | KIANA_SP_ERR_BRANCH_UNIT_INVALID_OP;
                else begin
                    grant_d = win_idx;
                    op_d = '{warp: req_warp_id[win_idx], op: req_branch_op[win_idx],
                             imm: req_address_imm[win_idx], pred: req_pred[win_idx]};
                    busy_d[req_warp_id[win_idx]] = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: if (m_tready_exe) begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (done_valid && done_warp_id == op_q.warp) begin
                    busy_d[op_q.warp] = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (done_valid) err_d = err_d | KIANA_SP_ERR_BRANCH_ARB_MISMATCH;
                    if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        err_d = err_d | KIANA_SP_ERR_BRANCH_ARB_TIMEOUT;
                        busy_d[op_q.warp] = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (state_q == IDLE) ? win_grant : '0;
        m_tvalid_exe = (state_q == ISSUE);
        warp_id_exe  = op_q.warp;
        branch_op    = op_q.op;
        address_imm  = op_q.imm;
        pred         = op_q.pred;
        warp_busy    = busy_q;
        grant_id     = grant_q;
        err          = err_q;
    end

endmodule

// File: tb/tb_branch_issue_arbiter.sv
// tb_branch_issue_arbiter: vector table, directed corner sequences and a randomized reference-model run
module tb_branch_issue_arbiter;
    import branch_issue_arbiter_pkg::*;

    localparam int N = 4;
    localparam int T = 8;
    localparam logic [31:0] INV = KIANA_SP_ERR_BRANCH_UNIT_INVALID_OP;
    localparam logic [31:0] MM  = KIANA_SP_ERR_BRANCH_ARB_MISMATCH;
    localparam logic [31:0] TO  = KIANA_SP_ERR_BRANCH_ARB_TIMEOUT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req_valid, req_ready;
    logic [N-1:0][4:0] req_warp_id;
    branch_op_t [N-1:0] req_branch_op;
    logic [N-1:0][31:0] req_address_imm, req_pred;
    logic m_tvalid_exe, m_tready_exe;
    logic [4:0] warp_id_exe;
    branch_op_t branch_op;
    logic [31:0] address_imm, pred;
    logic done_valid;
    logic [4:0] done_warp_id;
    logic [31:0] warp_busy, err;
    logic [1:0] grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_issue_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_warp_id(req_warp_id), .req_branch_op(req_branch_op),
        .req_address_imm(req_address_imm), .req_pred(req_pred),
        .m_tvalid_exe(m_tvalid_exe), .m_tready_exe(m_tready_exe),
        .warp_id_exe(warp_id_exe), .branch_op(branch_op),
        .address_imm(address_imm), .pred(pred),
        .done_valid(done_valid), .done_warp_id(done_warp_id),
        .warp_busy(warp_busy), .grant_id(grant_id), .err(err)
    );

    typedef struct {
        logic [3:0]  valid;
        logic        tready;
        logic        done;
        logic [4:0]  dw;
        logic [3:0]  ready;
        logic        tvalid;
        logic [31:0] busy;
        logic [31:0] e;
    } vec_t;

    vec_t tab[9];
    branch_op_t ops[6];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [4:0] w, input branch_op_t op, input logic [31:0] imm, input logic [31:0] p);
        req_warp_id[i] = w;
        req_branch_op[i] = op;
        req_address_imm[i] = imm;
        req_pred[i] = p;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        m_tready_exe = 1'b0;
        done_valid = 1'b0;
        done_warp_id = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b1;
    endtask

    // behavioural model state for the randomized run
    int m_last, m_cnt, m_grant, win, idx;
    bit m_pend, m_wait;
    logic [4:0] m_warp;
    branch_op_t m_op;
    logic [31:0] m_imm, m_pred, m_err, m_busy;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ops = '{BRA_NOP, BRA_PC_ADD_4, BRA_JUMP, BRA_BEQ, BRA_BNE, BRA_BLT};
        for (int i = 0; i < N; i++) set_req(i, 5'd0, BRA_NOP, 32'd0, 32'd0);
        idle_inputs();
        nxt();
        #1;
        chk("rst_tvalid", m_tvalid_exe, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", warp_busy, 0);
        chk("rst_err", err, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_op", branch_op, BRA_NOP);
        chk("rst_warp", warp_id_exe, 0);
        chk("rst_imm", address_imm, 0);
        do_reset();

        // single request then invalid op, cycle by cycle
        set_req(1, 5'd3, BRA_JUMP, 32'h100, 32'hFFFF);
        set_req(0, 5'd2, BRA_PC_ADD_4, 32'h4, 32'h1);
        tab[0] = '{4'b0010, 1'b1, 1'b0, 5'd0, 4'b0010, 1'b0, 32'h0, 32'h0};
        tab[1] = '{4'b0000, 1'b1, 1'b0, 5'd0, 4'b0000, 1'b1, 32'h8, 32'h0};
        tab[2] = '{4'b0000, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b0, 32'h8, 32'h0};
        tab[3] = '{4'b0000, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b0, 32'h8, 32'h0};
        tab[4] = '{4'b0000, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b0, 32'h8, 32'h0};
        tab[5] = '{4'b0000, 1'b0, 1'b1, 5'd3, 4'b0000, 1'b0, 32'h8, 32'h0};
        tab[6] = '{4'b0000, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b0, 32'h0, 32'h0};
        tab[7] = '{4'b0001, 1'b0, 1'b0, 5'd0, 4'b0001, 1'b0, 32'h0, 32'h0};
        tab[8] = '{4'b0000, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b0, 32'h0, INV};
        for (int i = 0; i < 9; i++) begin
            req_valid = tab[i].valid;
            m_tready_exe = tab[i].tready;
            done_valid = tab[i].done;
            done_warp_id = tab[i].dw;
            #1;
            chk($sformatf("tab%0d_ready", i), req_ready, tab[i].ready);
            chk($sformatf("tab%0d_tvalid", i), m_tvalid_exe, tab[i].tvalid);
            chk($sformatf("tab%0d_busy", i), warp_busy, tab[i].busy);
            chk($sformatf("tab%0d_err", i), err, tab[i].e);
            if (tab[i].tvalid) begin
                chk($sformatf("tab%0d_warp", i), warp_id_exe, 3);
                chk($sformatf("tab%0d_grant", i), grant_id, 1);
                chk($sformatf("tab%0d_imm", i), address_imm, 32'h100);
                chk($sformatf("tab%0d_op", i), branch_op, BRA_JUMP);
            end
            nxt();
        end

        // round-robin fairness: 4-cycle slots, done at slot cycle 3
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 5'(10 + i), BRA_BNE, 32'(i), 32'hF);
        req_valid = '1;
        m_tready_exe = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("rr%0d_ready", s), req_ready, 4'b0001 << (s % N));
            nxt();
            #1;
            chk($sformatf("rr%0d_grant", s), grant_id, s % N);
            chk($sformatf("rr%0d_warp", s), warp_id_exe, 10 + (s % N));
            nxt();
            nxt();
            done_valid = 1'b1;
            done_warp_id = 5'(10 + (s % N));
            nxt();
            done_valid = 1'b0;
        end

        // backpressure: 10 cycles without ready
        do_reset();
        set_req(2, 5'd9, BRA_BEQ, 32'hABC, 32'h5A5A);
        set_req(0, 5'd4, BRA_JUMP, 32'h1, 32'h1);
        req_valid = 4'b0100;
        #1;
        chk("bp_accept", req_ready, 4'b0100);
        nxt();
        req_valid = 4'b0101;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_tvalid", m_tvalid_exe, 1);
            chk("bp_ready", req_ready, 0);
            chk("bp_warp", warp_id_exe, 9);
            chk("bp_op", branch_op, BRA_BEQ);
            chk("bp_imm", address_imm, 32'hABC);
            chk("bp_pred", pred, 32'h5A5A);
            nxt();
        end
        m_tready_exe = 1'b1;
        #1;
        chk("bp_xfer_tvalid", m_tvalid_exe, 1);
        nxt();
        m_tready_exe = 1'b0;
        #1;
        chk("bp_wait_tvalid", m_tvalid_exe, 0);
        chk("bp_wait_ready", req_ready, 0);

        // done for a different warp while waiting
        do_reset();
        set_req(0, 5'd5, BRA_JUMP, 32'h20, 32'h3);
        set_req(1, 5'd1, BRA_BLT, 32'h30, 32'h3);
        req_valid = 4'b0001;
        m_tready_exe = 1'b1;
        nxt();
        req_valid = 4'b0000;
        nxt();
        req_valid = 4'b0010;
        done_valid = 1'b1;
        done_warp_id = 5'd7;
        nxt();
        #1;
        chk("mm_err", err, MM);
        chk("mm_busy", warp_busy, 32'h20);
        chk("mm_ready", req_ready, 0);
        done_warp_id = 5'd5;
        nxt();
        done_valid = 1'b0;
        #1;
        chk("mm_done_busy", warp_busy, 0);
        chk("mm_done_ready", req_ready, 4'b0010);

        // timeout after T wait cycles
        do_reset();
        set_req(0, 5'd6, BRA_JUMP, 32'h40, 32'h1);
        req_valid = 4'b0001;
        m_tready_exe = 1'b1;
        nxt();
        req_valid = 4'b0000;
        nxt();
        for (int c = 0; c < T; c++) begin
            #1;
            chk("to_busy", warp_busy, 32'h40);
            chk("to_err_early", err, 0);
            nxt();
        end
        req_valid = 4'b0001;
        #1;
        chk("to_err", err, TO);
        chk("to_busy_clr", warp_busy, 0);
        chk("to_idle_ready", req_ready, 4'b0001);

        // async reset while an op sits in ISSUE
        do_reset();
        set_req(0, 5'd2, BRA_PC_ADD_4, 32'h0, 32'h0);
        req_valid = 4'b0001;
        nxt();
        set_req(0, 5'd8, BRA_JUMP, 32'h77, 32'h7);
        nxt();
        req_valid = 4'b0000;
        #1;
        chk("ar_issue_tvalid", m_tvalid_exe, 1);
        chk("ar_issue_err", err, INV);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_tvalid", m_tvalid_exe, 0);
        chk("ar_busy", warp_busy, 0);
        chk("ar_err", err, 0);
        chk("ar_grant", grant_id, 0);
        chk("ar_op", branch_op, BRA_NOP);
        chk("ar_warp", warp_id_exe, 0);
        nxt();
        rst_n = 1'b1;
        done_valid = 1'b1;
        done_warp_id = 5'd8;
        nxt();
        done_valid = 1'b0;
        #1;
        chk("ar_late_done_err", err, 0);
        chk("ar_late_done_busy", warp_busy, 0);

        // randomized run against the behavioural model
        do_reset();
        m_last = N - 1; m_pend = 0; m_wait = 0; m_cnt = 0; m_grant = 0; m_err = 0;
        m_warp = 0; m_op = BRA_NOP; m_imm = 0; m_pred = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = 1'($urandom_range(0, 1));
                set_req(i, 5'($urandom), ops[$urandom_range(0, 5)], $urandom, $urandom);
            end
            m_tready_exe = 1'($urandom_range(0, 1));
            done_valid = ($urandom_range(0, 3) == 0);
            done_warp_id = ($urandom_range(0, 2) != 0) ? m_warp : 5'($urandom);
            #1;
            m_busy = (m_pend || m_wait) ? (32'd1 << m_warp) : 32'd0;
            win = -1;
            if (!m_pend && !m_wait)
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (win < 0 && req_valid[idx] && !m_busy[req_warp_id[idx]]) win = idx;
                end
            chk("rnd_ready", req_ready, (win < 0) ? 64'd0 : (64'd1 << win));
            chk("rnd_tvalid", m_tvalid_exe, m_pend);
            chk("rnd_busy", warp_busy, m_busy);
            chk("rnd_grant", grant_id, m_grant);
            chk("rnd_err", err, m_err);
            chk("rnd_warp", warp_id_exe, m_warp);
            chk("rnd_op", branch_op, m_op);
            chk("rnd_imm", address_imm, m_imm);
            chk("rnd_pred", pred, m_pred);
            if (win >= 0) begin
                m_last = win;
                if (req_branch_op[win] == BRA_NOP || req_branch_op[win] == BRA_PC_ADD_4) m_err |= INV;
                else begin
                    m_pend = 1; m_grant = win;
                    m_warp = req_warp_id[win]; m_op = req_branch_op[win];
                    m_imm = req_address_imm[win]; m_pred = req_pred[win];
                end
            end else if (m_pend) begin
                if (m_tready_exe) begin m_pend = 0; m_wait = 1; m_cnt = 0; end
            end else if (m_wait) begin
                m_cnt++;
                if (done_valid && done_warp_id == m_warp) m_wait = 0;
                else begin
                    if (done_valid) m_err |= MM;
                    if (m_cnt == T) begin m_err |= TO; m_wait = 0; end
                end
            end
            nxt();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
